// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: square-and-multiply sequencer computing result_bar = base_bar^exp in the Montgomery domain
// Drives one montgomery_mul operation at a time over its taken/ready_in/ready_out/given handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   base_bar, exp, taken       job input, accepted while ready_in=1
//   ready_in, busy             controller status
//   result_bar, ready_out      result, held until given
//   given                      downstream consumes result_bar
//   mul_a, mul_b, mul_taken    operands and request to montgomery_mul
//   mul_ready_in               montgomery_mul can accept an operation
//   mul_out, mul_ready_out     montgomery_mul result and its valid
//   mul_given                  consume the montgomery_mul result
// Optional feature macro: MONT_EXP_LZ_SKIP_EN (start from the highest set exponent bit).
module mont_exp_ctrl #(
  parameter int          EXP_W        = 64,
  parameter logic [63:0] ONE_BAR      = 64'h000000000000000F,
  parameter int          DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      base_bar,
  input  logic [EXP_W-1:0] exp,
  input  logic             taken,
  output logic             ready_in,
  output logic [63:0]      result_bar,
  output logic             ready_out,
  input  logic             given,
  output logic             busy,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  output logic             mul_taken,
  input  logic             mul_ready_in,
  input  logic [63:0]      mul_out,
  input  logic             mul_ready_out,
  output logic             mul_given
);
  localparam int IW = $clog2(EXP_W);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [2:0] S_DRAIN     = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_SQ_ISSUE  = 3'd2;
  localparam logic [2:0] S_SQ_WAIT   = 3'd3;
  localparam logic [2:0] S_MUL_ISSUE = 3'd4;
  localparam logic [2:0] S_MUL_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    drain_q, drain_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [63:0]      result_q, result_d;
  logic             ready_out_q, ready_out_d;

`ifdef MONT_EXP_LZ_SKIP_EN
  logic [IW-1:0] hi;
  always_comb begin
    hi = '0;
    for (int k = 0; k < EXP_W; k++)
      if (exp[k]) hi = IW'(k);
  end
`endif

  assign ready_in   = state_q == S_IDLE;
  assign busy       = state_q != S_IDLE;
  assign result_bar = result_q;
  assign ready_out  = ready_out_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    acc_d       = acc_q;
    base_d      = base_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    result_d    = result_q;
    ready_out_d = ready_out_q;
    mul_a       = '0;
    mul_b       = '0;
    mul_taken   = 1'b0;
    mul_given   = 1'b0;
    case (state_q)
      // montgomery_mul has no reset: swallow anything still in flight
      S_DRAIN: begin
        mul_given = mul_ready_out;
        state_d   = drain_q == '0 ? S_IDLE : S_DRAIN;
        drain_d   = drain_q == '0 ? drain_q : drain_q - CW'(1);
      end
      S_IDLE: if (taken) begin
        base_d = base_bar;
        exp_d  = exp;
`ifdef MONT_EXP_LZ_SKIP_EN
        // leading squarings of ONE_BAR and the first multiply are identities
        acc_d   = exp == '0 ? ONE_BAR : base_bar;
        idx_d   = hi - IW'(1);
        state_d = (exp == '0 || hi == '0) ? S_DONE : S_SQ_ISSUE;
`else
        acc_d   = ONE_BAR;
        idx_d   = IW'(EXP_W - 1);
        state_d = exp == '0 ? S_DONE : S_SQ_ISSUE;
`endif
      end
      S_SQ_ISSUE: begin
        mul_a     = acc_q;
        mul_b     = acc_q;
        mul_taken = mul_ready_in;
        state_d   = mul_ready_in ? S_SQ_WAIT : S_SQ_ISSUE;
      end
      S_SQ_WAIT: begin
        mul_given = mul_ready_out;
        if (mul_ready_out) begin
          acc_d   = mul_out;
          state_d = exp_q[idx_q] ? S_MUL_ISSUE : idx_q == '0 ? S_DONE : S_SQ_ISSUE;
          idx_d   = (!exp_q[idx_q] && idx_q != '0) ? idx_q - IW'(1) : idx_q;
        end
      end
      S_MUL_ISSUE: begin
        mul_a     = acc_q;
        mul_b     = base_q;
        mul_taken = mul_ready_in;
        state_d   = mul_ready_in ? S_MUL_WAIT : S_MUL_ISSUE;
      end
      S_MUL_WAIT: begin
        mul_given = mul_ready_out;
        if (mul_ready_out) begin
          acc_d   = mul_out;
          state_d = idx_q == '0 ? S_DONE : S_SQ_ISSUE;
          idx_d   = idx_q == '0 ? idx_q : idx_q - IW'(1);
        end
      end
      // first DONE cycle registers the result; ready_out follows one cycle later
      S_DONE: begin
        result_d    = acc_q;
        ready_out_d = !(ready_out_q && given);
        state_d     = (ready_out_q && given) ? S_IDLE : S_DONE;
      end
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DRAIN;
      drain_q     <= CW'(DRAIN_CYCLES - 1);
      acc_q       <= '0;
      base_q      <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      ready_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      ready_out_q <= ready_out_d;
    end
  end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: directed bench for mont_exp_ctrl with a behavioural montgomery_mul (latency 4, no reset)
module tb_mont_exp_ctrl;
  localparam logic [63:0] N   = 64'hFFFFFFFFFFFFFFF1;
  localparam logic [63:0] ONE = 64'h000000000000000F;
`ifdef MONT_EXP_LZ_SKIP_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [63:0] base_bar = '0;
  logic [63:0] exp_v = '0;
  logic taken = 1'b0;
  logic given = 1'b0;
  logic ready_in, ready_out, busy, mul_taken, mul_given, mul_ready_in, mul_ready_out;
  logic [63:0] result_bar, mul_a, mul_b, mul_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .base_bar(base_bar), .exp(exp_v), .taken(taken),
    .ready_in(ready_in), .result_bar(result_bar), .ready_out(ready_out), .given(given),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_taken(mul_taken),
    .mul_ready_in(mul_ready_in), .mul_out(mul_out), .mul_ready_out(mul_ready_out),
    .mul_given(mul_given)
  );

  // bit-serial REDC: a*b*2^-64 mod N
  function automatic logic [63:0] montmul(input logic [63:0] a, input logic [63:0] b);
    logic [65:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) t = t + {2'b0, b};
      if (t[0]) t = t + {2'b0, N};
      t = t >> 1;
    end
    if (t >= {2'b0, N}) t = t - {2'b0, N};
    return t[63:0];
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = ({64'b0, a} * {64'b0, b}) % {64'b0, N};
    return p[63:0];
  endfunction

  function automatic logic [63:0] to_mont(input logic [63:0] x);
    logic [127:0] p;
    p = {x, 64'b0} % {64'b0, N};
    return p[63:0];
  endfunction

  // multiplier stand-in: one slot, result visible 4 cycles after the take, never reset
  logic sv = 1'b0;
  logic [2:0] scnt = '0;
  logic [63:0] sres = '0;
  logic en = 1'b1;
  logic stale = 1'b0;
  int takes = 0;
  assign mul_ready_in  = en && !sv;
  assign mul_ready_out = sv && scnt == 3'd0;
  assign mul_out       = sres;

  always @(posedge clk) begin
    if ((mul_taken || stale) && mul_ready_in) begin
      sv   <= 1'b1;
      scnt <= 3'd3;
      sres <= stale ? montmul(64'h0123456789ABCDEF, 64'h0FEDCBA987654321) : montmul(mul_a, mul_b);
    end else if (sv) begin
      if (scnt != 3'd0) scnt <= scnt - 3'd1;
      else if (mul_given) sv <= 1'b0;
    end
    if (mul_taken && mul_ready_in) takes <= takes + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!ready_in && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n), 64'd8);
    chk({tag, "_mul_empty"}, {63'b0, sv}, 64'd0);
  endtask

  task automatic start(input logic [63:0] b, input logic [63:0] e);
    int n;
    n = 0;
    while (!ready_in && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    base_bar = b;
    exp_v    = e;
    taken    = 1'b1;
    @(posedge clk); #1;
    taken    = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!ready_out && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic give();
    given = 1'b1;
    @(posedge clk); #1;
    given = 1'b0;
  endtask

  task automatic job(input string tag, input logic [63:0] b, input logic [63:0] e,
                     input logic [63:0] want, input int ops);
    int t0, n;
    t0 = takes;
    start(b, e);
    wait_out(n);
    chk({tag, "_latency"}, 64'(n), 64'(2 + 5 * ops));
    chk({tag, "_result"}, result_bar, want);
    chk({tag, "_mul_ops"}, 64'(takes - t0), 64'(ops));
    give();
    chk({tag, "_release"}, {62'b0, ready_out, ready_in}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x5, x3, r;
    int n, t0;
    x5 = to_mont(64'd5);
    x3 = to_mont(64'd3);
    r = 64'd3;
    for (int i = 0; i < 16; i++) r = mulmod(r, r);
    r = mulmod(r, 64'd3);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_in", {63'b0, ready_in}, 64'd0);
    chk("rst_ready_out", {63'b0, ready_out}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd1);
    chk("rst_result", result_bar, 64'd0);
    chk("rst_mul_taken", {63'b0, mul_taken}, 64'd0);
    chk("rst_mul_ab", mul_a | mul_b, 64'd0);
    stale = 1'b1;
    @(posedge clk); #1;
    stale = 1'b0;
    rst_n = 1'b1;
    wait_drain("drain");
    chk("idle_busy", {63'b0, busy}, 64'd0);

    job("exp0", 64'h1234, 64'd0, ONE, 0);
    job("exp1", x5, 64'd1, x5, LZ ? 0 : 65);
    job("exp65537", x3, 64'h10001, to_mont(r), LZ ? 17 : 66);

    en = 1'b0;
    t0 = takes;
    start(x5, 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_mul_a", mul_a, LZ ? x5 : ONE);
      chk("bp_mul_b", mul_b, LZ ? x5 : ONE);
      chk("bp_mul_taken", {62'b0, mul_taken, busy}, 64'd1);
      @(posedge clk); #1;
    end
    en = 1'b1;
    #1;
    chk("bp_release_taken", {63'b0, mul_taken}, 64'd1);
    wait_out(n);
    chk("bp_result", result_bar, to_mont(64'd125));
    chk("bp_mul_ops", 64'(takes - t0), LZ ? 64'd2 : 64'd66);
    for (int i = 0; i < 10; i++) begin
      chk("hold_ready", {62'b0, ready_out, ready_in}, 64'd2);
      chk("hold_result", result_bar, to_mont(64'd125));
      @(posedge clk); #1;
    end
    give();
    chk("hold_release", {62'b0, ready_out, ready_in}, 64'd1);

    start(x3, 64'h10001);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_op", {61'b0, ready_in, busy, mul_taken}, 64'd2);
    chk("abort_mul_a", mul_a, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_drain("redrain_op");

    start(64'h1234, 64'd0);
    wait_out(n);
    chk("pre_abort_ready", {63'b0, ready_out}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_done", {62'b0, ready_out, busy}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_drain("redrain_done");
    job("after_abort", x5, 64'd1, x5, LZ ? 0 : 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Square-and-multiply sequencer computing result_bar = base_bar^exp in the Montgomery domain (N = 0xFFFFFFFFFFFFFFF1, R = 2^64).
- Sits directly upstream of montgomery_mul and drives its taken/ready_in/ready_out/given interface one operation at a time.
- Operands arrive already converted by montgomery_convert_in; the result goes to montgomery_convert_out.

Parameters:
- EXP_W, 64, exponent width in bits; the bit counter is clog2(EXP_W) bits wide.
- ONE_BAR, 64'h000000000000000F, Montgomery form of 1 (R mod N).
- DRAIN_CYCLES, 8, post-reset cycles spent flushing the multiplier; must be ≥ multiplier latency + 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- base_bar  in  64  base in Montgomery form, sampled on taken
- exp  in  EXP_W  exponent, sampled on taken
- taken  in  1  upstream transfers a job this cycle; legal only while ready_in=1
- ready_in  out  1  controller can accept a job
- result_bar  out  64  base_bar^exp in Montgomery form
- ready_out  out  1  result_bar valid; held until given
- given  in  1  downstream consumes result_bar this cycle
- busy  out  1  high in every state except IDLE
- mul_a  out  64  multiplier operand a_bar
- mul_b  out  64  multiplier operand b_bar
- mul_taken  out  1  to montgomery_mul taken
- mul_ready_in  in  1  from montgomery_mul ready_in
- mul_out  in  64  from montgomery_mul out_bar
- mul_ready_out  in  1  from montgomery_mul ready_out
- mul_given  out  1  to montgomery_mul given

Behaviour:
- Reset (async assert, sync release): enter DRAIN with drain counter = DRAIN_CYCLES-1. Reset values: ready_in=0, ready_out=0, busy=1, result_bar=0, mul_taken=0, mul_a=0, mul_b=0.
  - mul_given = mul_ready_out throughout DRAIN. montgomery_mul has no reset, so stale in-flight results are consumed and discarded.
- States: DRAIN, IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- DRAIN -> IDLE when the counter reaches 0.
- IDLE: ready_in=1, busy=0, mul_given=0. On taken:
  - latch base and exp, set acc=ONE_BAR, bit index i=EXP_W-1;
  - go to SQ_ISSUE, or directly to DONE with result_bar=ONE_BAR if exp==0.
- SQ_ISSUE: mul_a=mul_b=acc; mul_taken = mul_ready_in. On that handshake go to SQ_WAIT.
- SQ_WAIT: mul_given = mul_ready_out. On that handshake, acc <= mul_out, then:
  - if exp_reg[i]==1, go to MUL_ISSUE;
  - else if i==0, go to DONE;
  - else decrement i and go to SQ_ISSUE.
- MUL_ISSUE/MUL_WAIT: same handshakes with mul_a=acc, mul_b=base_reg. After capture: DONE if i==0, else decrement i and go to SQ_ISSUE.
- DONE: result_bar=acc, ready_out=1. On given go to IDLE next cycle. ready_in=0 in DONE, so taken and given never coincide.
- At most one multiplier operation is in flight. mul_taken and mul_given are never high outside the matching ISSUE/WAIT state (or DRAIN for mul_given).
- mul_a and mul_b stay stable while mul_taken is pending, i.e. mul_ready_in=0.
- Per-op cost = L+1 cycles, where L is the multiplier latency from mul_taken to mul_ready_out (4 for montgomery_mul), so 5 cycles per op.
- Job latency without the optional feature: taken -> ready_out = 1 + (EXP_W + popcount(exp))*(L+1) + 1 cycles, assuming mul_ready_in=1.
- taken while ready_in=0 is ignored. Asserting rst_n=0 mid-job aborts the job with no result, then the controller re-drains.

Optional Feature:
- Macro: MONT_EXP_LZ_SKIP_EN.
- Defined:
  - on taken, if exp != 0, find the highest set bit h with a priority encoder;
  - set acc=base_bar and i=h, skipping squarings of ONE_BAR and the first multiply;
  - if h==0, go to DONE directly with result_bar=base_bar;
  - otherwise enter SQ_ISSUE with i=h-1.
  - Op count becomes h + popcount(exp) - 1.
- Undefined: full EXP_W iterations starting from acc=ONE_BAR, exactly as described under Behaviour.

Test Plan:
- Reset then idle: ready_in=0 for exactly DRAIN_CYCLES cycles, then 1. Pre-load the multiplier with a stale op before reset -> it is drained, and the first job's result is unaffected.
- exp=0, base_bar=0x1234 -> ready_out 2 cycles after taken, result_bar=0xF, zero mul_taken pulses.
- exp=1, base_bar=X=convert_in(5) -> result_bar=X.
  - Without the macro: 64 squares + 1 multiply, 65 mul_taken pulses.
  - With the macro: 0 pulses.
- exp=0x10001 (65537), base=convert_in(3) -> convert_out(result_bar) equals 3^65537 mod N from the reference model.
  - Mul transaction count: 66 without the macro, 17 with it.
- Backpressure: hold mul_ready_in=0 for 3 cycles during SQ_ISSUE -> mul_a/mul_b stable and mul_taken held; result is unchanged.
- Hold given=0 for 10 cycles in DONE -> ready_out and result_bar stable and ready_in=0. Assert rst_n=0 mid-job -> ready_out=0 immediately and the controller re-enters DRAIN.
